// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: field slices, HALT opcode, FSM states.
package fetch_unit_pkg;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int OP_MSB  = 12;
    localparam int OP_LSB  = 11;

    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam int PC_W_DEF = 9;
    typedef logic [PC_W_DEF-1:0] pc_t;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_BOOT = 2'd0;
    localparam fetch_state_t ST_RUN  = 2'd1;
    localparam fetch_state_t ST_HALT = 2'd2;
endpackage

// File: rtl/fetch_replay_buf.sv
// One-entry holding register for a fetched word and its address.
// Latency: captured word visible the cycle after capture.
// Backpressure: capture is ignored while full; flush beats capture and consume.
module fetch_replay_buf #(
    parameter int DW = 16,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          capture,
    input  logic          consume,
    input  logic          flush,
    input  logic [DW-1:0] cap_instr,
    input  logic [AW-1:0] cap_addr,
    output logic          buf_valid,
    output logic [DW-1:0] buf_instr,
    output logic [AW-1:0] buf_addr
);
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_instr <= '0;
            buf_addr  <= '0;
        end else if (flush) begin
            buf_valid <= 1'b0;
        end else if (capture && !buf_valid) begin
            buf_valid <= 1'b1;
            buf_instr <= cap_instr;
            buf_addr  <= cap_addr;
        end else if (consume) begin
            buf_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch + IF/ID register; optional counters under FETCH_PERF_EN.
// Latency: 1-cycle synchronous memory read plus the IF/ID register; redirect target lands two edges later.
// Backpressure: stall / !pc_load hold PC and IF/ID; the in-flight word is parked in a replay buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               pc_load,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [2:0]         if_id_opcode,
    output logic [1:0]         if_id_op,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [PC_W-1:0]    if_id_pc_next,
    output logic               if_id_valid,
`ifdef FETCH_PERF_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall,
`endif
    output logic               halted
);
    fetch_state_t        state;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     rd_addr_q;
    logic                rd_q;
    logic                buf_valid;
    logic [INSTR_W-1:0]  buf_instr;
    logic [PC_W-1:0]     buf_addr;
    logic [INSTR_W-1:0]  word_in;
    logic [PC_W-1:0]     addr_in;
    logic                have_word;
    logic                halt_in_ifid;
    logic                incoming_halt;
    logic                hold;
    logic                rd_en;
    logic                advance;
    logic                load;
    logic                capture;
    logic                flush;

    assign hold          = stall || !pc_load;
    assign imem_addr     = redirect ? redirect_pc : pc;
    assign word_in       = buf_valid ? buf_instr : imem_rdata;
    assign addr_in       = buf_valid ? buf_addr : rd_addr_q;
    assign have_word     = buf_valid || rd_q;
    assign halt_in_ifid  = if_id_valid && (if_id_instr[OPC_MSB:OPC_LSB] == OPC_HALT);
    assign incoming_halt = have_word && (word_in[OPC_MSB:OPC_LSB] == OPC_HALT);

    always_comb begin
        rd_en   = 1'b0;
        advance = 1'b0;
        load    = 1'b0;
        capture = 1'b0;
        flush   = 1'b0;
        case (state)
            ST_BOOT: rd_en = 1'b1;
            ST_RUN: begin
                if (redirect) begin
                    rd_en = 1'b1;
                    flush = 1'b1;
                end else if (halt_in_ifid) begin
                    rd_en = 1'b0;
                end else if (hold) begin
                    capture = rd_q;
                end else begin
                    // A HALT word on its way into IF/ID stops fetching at once.
                    advance = 1'b1;
                    load    = have_word;
                    rd_en   = !incoming_halt;
                end
            end
            default: rd_en = 1'b0;
        endcase
    end

    assign imem_rd = rd_en && !reset;

    fetch_replay_buf #(.DW(INSTR_W), .AW(PC_W)) u_replay (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture),
        .consume   (load && buf_valid),
        .flush     (flush),
        .cap_instr (imem_rdata),
        .cap_addr  (rd_addr_q),
        .buf_valid (buf_valid),
        .buf_instr (buf_instr),
        .buf_addr  (buf_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            rd_q        <= 1'b0;
            rd_addr_q   <= '0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else begin
            rd_q <= rd_en;
            if (rd_en) begin
                rd_addr_q <= imem_addr;
                pc        <= imem_addr + PC_W'(1);
            end
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN:  if (!redirect && halt_in_ifid) state <= ST_HALT;
                default: state <= state;
            endcase
            if (state == ST_RUN && redirect) begin
                if_id_valid <= 1'b0;
            end else if (advance) begin
                if_id_valid <= load;
                if (load) begin
                    if_id_instr <= word_in;
                    if_id_pc    <= addr_in;
                end
            end
        end
    end

    assign if_id_opcode  = if_id_instr[OPC_MSB:OPC_LSB];
    assign if_id_op      = if_id_instr[OP_MSB:OP_LSB];
    assign if_id_pc_next = if_id_pc + PC_W'(1);
    assign halted        = (state == ST_HALT);

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (load && perf_fetched != '1)
                perf_fetched <= perf_fetched + 32'd1;
            if (state == ST_RUN && hold && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed fetch, stall, redirect, HALT and PC-wrap scenarios.
module tb_fetch_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, pc_load, redirect;
    logic [8:0]  redirect_pc;
    logic [8:0]  imem_addr;
    logic        imem_rd;
    logic [15:0] imem_rdata = '0;
    logic [15:0] if_id_instr;
    logic [2:0]  if_id_opcode;
    logic [1:0]  if_id_op;
    logic [8:0]  if_id_pc, if_id_pc_next;
    logic        if_id_valid, halted;

    logic [3:0]  imem_addr2, if_id_pc2, if_id_pc_next2;
    logic        imem_rd2, if_id_valid2, halted2;
    logic [15:0] imem_rdata2 = '0;
    logic [15:0] if_id_instr2;
    logic [2:0]  if_id_opcode2;
    logic [1:0]  if_id_op2;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif

    fetch_unit #(.PC_W(9), .INSTR_W(16), .RESET_PC(9'd0)) u_dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_rdata(imem_rdata), .stall(stall), .pc_load(pc_load),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode), .if_id_op(if_id_op),
        .if_id_pc(if_id_pc), .if_id_pc_next(if_id_pc_next), .if_id_valid(if_id_valid),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched), .perf_stall(perf_stall),
`endif
        .halted(halted)
    );

    fetch_unit #(.PC_W(4), .INSTR_W(16), .RESET_PC(4'd14)) u_wrap (
        .clk(clk), .reset(reset), .imem_addr(imem_addr2), .imem_rd(imem_rd2),
        .imem_rdata(imem_rdata2), .stall(1'b0), .pc_load(1'b1),
        .redirect(1'b0), .redirect_pc(4'd0),
        .if_id_instr(if_id_instr2), .if_id_opcode(if_id_opcode2), .if_id_op(if_id_op2),
        .if_id_pc(if_id_pc2), .if_id_pc_next(if_id_pc_next2), .if_id_valid(if_id_valid2),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched2), .perf_stall(perf_stall2),
`endif
        .halted(halted2)
    );

    logic [15:0] mem [0:511];
    always @(posedge clk) if (imem_rd) imem_rdata <= mem[imem_addr];
    always @(posedge clk) if (imem_rd2) imem_rdata2 <= {12'h010, imem_addr2};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    typedef struct packed {
        logic [8:0]  pc;
        logic [15:0] instr;
    } exp_t;
    exp_t       q[$];
    logic [3:0] q2[$];

    task automatic push(input logic [8:0] p);
        exp_t e;
        e.pc    = p;
        e.instr = mem[p];
        q.push_back(e);
    endtask

    // Decode consumes IF/ID when it is not stalled, or when it resolves a redirect.
    always @(negedge clk) begin
        if (!reset && if_id_valid && !halted && (redirect || (!stall && pc_load))) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected actual=pc %h required=none", if_id_pc);
            end else begin
                exp_t       e;
                logic [8:0] nx;
                e  = q.pop_front();
                nx = e.pc + 9'd1;
                check("sb_pc", if_id_pc, e.pc);
                check("sb_instr", if_id_instr, e.instr);
                check("sb_pc_next", if_id_pc_next, nx);
                check("sb_opcode", if_id_opcode, e.instr[15:13]);
                check("sb_op", if_id_op, e.instr[12:11]);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && if_id_valid2 && q2.size() > 0) begin
            logic [3:0] p;
            p = q2.pop_front();
            check("wrap_pc", if_id_pc2, p);
            check("wrap_instr", if_id_instr2, {12'h010, p});
`ifdef FETCH_PERF_EN
            if (q2.size() == 0) check("wrap_perf_fetched", perf_fetched2, 32'd4);
`endif
        end
    end

    task automatic wait_pc(input logic [8:0] p);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk); #1;
            if (if_id_valid && if_id_pc == p) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL wait_pc actual=timeout required=pc %h", p);
        end
    endtask

    initial begin
        int rd_seen;
        for (int i = 0; i < 512; i++) mem[i] = 16'(i);
        mem[7]    = 16'hE000;
        mem[9'h41] = 16'h5841;
        mem[9'h42] = 16'h3042;
        q2.push_back(4'd14); q2.push_back(4'd15); q2.push_back(4'd0); q2.push_back(4'd1);

        reset = 1'b1; stall = 1'b0; pc_load = 1'b1; redirect = 1'b0; redirect_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", if_id_valid, 0);
        check("rst_pc", if_id_pc, 0);
        check("rst_instr", if_id_instr, 0);
        check("rst_halted", halted, 0);
        check("rst_imem_rd", imem_rd, 0);

        for (int i = 0; i <= 5; i++) push(9'(i));
        push(9'h40); push(9'h41); push(9'd5); push(9'd6); push(9'd7);

        reset = 1'b0;
        @(posedge clk); #1;
        check("edge1_valid", if_id_valid, 0);
        @(posedge clk); #1;
        check("edge2_valid", if_id_valid, 1);
        check("edge2_pc", if_id_pc, 0);

        wait_pc(9'd2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_no_read", imem_rd, 0);
            check("stall_hold_pc", if_id_pc, 2);
            @(posedge clk); #1;
        end
        check("stall_end_pc", if_id_pc, 2);
        stall = 1'b0;
        @(posedge clk); #1;
        check("resume_pc3", if_id_pc, 3);
        @(posedge clk); #1;
        check("resume_pc4", if_id_pc, 4);

        wait_pc(9'd5);
        redirect = 1'b1; redirect_pc = 9'h40;
        #1;
        check("redir_addr", imem_addr, 9'h40);
        check("redir_rd", imem_rd, 1);
        @(posedge clk); #1;
        redirect = 1'b0;
        check("redir_bubble", if_id_valid, 0);
        @(posedge clk); #1;
        check("redir_target_valid", if_id_valid, 1);
        check("redir_target_pc", if_id_pc, 9'h40);

        wait_pc(9'h41);
        stall = 1'b1;
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 9'd5;
        @(posedge clk); #1;
        redirect = 1'b0; stall = 1'b0;
        check("redir_stall_bubble", if_id_valid, 0);
        @(posedge clk); #1;
        check("redir_stall_pc", if_id_pc, 5);

        wait_pc(9'd7);
        check("halt_word_opcode", if_id_opcode, 3'b111);
        check("halt_not_yet", halted, 0);
        @(posedge clk); #1;
        check("halted_next", halted, 1);
        rd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_rd !== 1'b0 || if_id_pc !== 9'd7) rd_seen++;
            @(posedge clk); #1;
        end
        check("halt_quiet", rd_seen, 0);
        check("sb_drained", q.size(), 0);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rerst_halted", halted, 0);
        push(9'd0); push(9'd1); push(9'd2);
        reset = 1'b0;
        wait_pc(9'd2);
        @(negedge clk); #1;
        stall = 1'b1;
        check("restart_drained", q.size(), 0);
        check("wrap_drained", q2.size(), 0);
        check("wrap_not_halted", halted2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
